// File: rtl/paddle_pkg.sv
// paddle_pkg: shared types and helpers for the paddle controller.
//   paddle_state_t : movement FSM states (IDLE, SLOW, FAST)
//   paddle_dir_t   : direction request / latched direction (NONE, UP, DOWN)
//   center()       : rest row of the paddle top for a given geometry
package paddle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } paddle_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } paddle_dir_t;

  function automatic int center(input int game_height, input int paddle_height);
    return (game_height - paddle_height) / 2;
  endfunction

endpackage

// File: rtl/paddle_step_timer.sv
// paddle_step_timer: step-rate counter for the paddle.
//   clock, reset : system clock, async active-high reset
//   clear        : forces the count back to 0 on the next edge
//   fast         : 1 selects FAST_TICKS as the period, 0 selects SLOW_TICKS
//   tick         : high for the one cycle where the count sits at period-1
// The tick does not depend on clear, so the owner may derive clear from tick
// without forming a combinational loop.
module paddle_step_timer #(
  parameter int SLOW_TICKS = 1250000,
  parameter int FAST_TICKS = 625000,
  parameter int CNT_W      = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic fast,
  output logic tick
);

  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_TICKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == (fast ? FAST_LAST : SLOW_LAST));
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: accelerating, wall-clamped paddle position with draw strobe.
//   clock, reset          : system clock, async active-high reset
//   game_active           : low recentres the paddle and parks the FSM
//   icolcount, irowcount  : cell currently being drawn
//   iup, idown            : buttons
//   iauto, iballY         : auto-track mode and ball row (PADDLE_AUTO_EN only)
//   odrawpaddle           : registered "this cell is paddle" strobe
//   opaddley              : top row of the paddle
//   omoving               : one-cycle pulse whenever opaddley changes
// Optional feature macro: PADDLE_AUTO_EN adds the CPU-player tracking mode.
module paddle_ctrl
  import paddle_pkg::*;
#(
  parameter int GAME_WIDTH    = 40,
  parameter int GAME_HEIGHT   = 30,
  parameter int COORD_W       = 6,
  parameter int PADDLE_X      = 0,
  parameter int PADDLE_HEIGHT = 6,
  parameter int SLOW_TICKS    = 1250000,
  parameter int FAST_TICKS    = 625000,
  parameter int ACCEL_STEPS   = 4,
  parameter int CNT_W         = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               game_active,
  input  logic [COORD_W-1:0] icolcount,
  input  logic [COORD_W-1:0] irowcount,
  input  logic               iup,
  input  logic               idown,
`ifdef PADDLE_AUTO_EN
  input  logic               iauto,
  input  logic [COORD_W-1:0] iballY,
`endif
  output logic               odrawpaddle,
  output logic [COORD_W-1:0] opaddley,
  output logic               omoving
);

  localparam int STEP_W = $clog2(ACCEL_STEPS + 1);
  localparam logic [COORD_W-1:0] CENTER_Y = COORD_W'(center(GAME_HEIGHT, PADDLE_HEIGHT));
  localparam logic [COORD_W-1:0] MAX_Y    = COORD_W'(GAME_HEIGHT - PADDLE_HEIGHT);
  localparam logic [COORD_W-1:0] COL_X    = COORD_W'(PADDLE_X);
  localparam logic [COORD_W:0]   PH_EXT   = (COORD_W+1)'(PADDLE_HEIGHT);
  localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(ACCEL_STEPS - 1);

  paddle_state_t      state_q, state_d;
  paddle_dir_t        dir_q, dir_d, req;
  logic [STEP_W-1:0]  steps_q, steps_d;
  logic [COORD_W-1:0] pady_q, pady_d;
  logic               moving_q, moving_d;
  logic               draw_q, draw_d;
  logic               tick, timer_clr, can_move;

  paddle_step_timer #(
    .SLOW_TICKS(SLOW_TICKS),
    .FAST_TICKS(FAST_TICKS),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .clear(timer_clr),
    .fast (state_q == FAST),
    .tick (tick)
  );

  // Direction request
  always_comb begin
    req = NONE;
    if (iup && !idown)      req = UP;
    else if (idown && !iup) req = DOWN;
`ifdef PADDLE_AUTO_EN
    if (iauto) begin
      // Aim the paddle's middle row at the ball; extra bit keeps the sum from wrapping.
      if ({1'b0, iballY} < ({1'b0, pady_q} + (PH_EXT >> 1)))      req = UP;
      else if ({1'b0, iballY} > ({1'b0, pady_q} + (PH_EXT >> 1))) req = DOWN;
      else                                                         req = NONE;
    end
`endif
  end

  // Movement FSM. A direction change takes priority over a coincident tick.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    steps_d   = steps_q;
    pady_d    = pady_q;
    timer_clr = (state_q == IDLE);
    can_move  = (dir_q == UP) ? (pady_q != '0) : (pady_q < MAX_Y);

    if (!game_active) begin
      state_d   = IDLE;
      dir_d     = NONE;
      steps_d   = '0;
      pady_d    = CENTER_Y;
      timer_clr = 1'b1;
    end else if (state_q == IDLE) begin
      if (req != NONE) begin
        state_d = SLOW;
        dir_d   = req;
        steps_d = '0;
      end
    end else if (req == NONE) begin
      state_d   = IDLE;
      dir_d     = NONE;
      steps_d   = '0;
      timer_clr = 1'b1;
    end else if (req != dir_q) begin
      state_d   = SLOW;
      dir_d     = req;
      steps_d   = '0;
      timer_clr = 1'b1;
    end else if (tick && can_move) begin
      pady_d = (dir_q == UP) ? pady_q - 1'b1 : pady_q + 1'b1;
      if (state_q == SLOW) begin
        if (steps_q == LAST_STEP) begin
          state_d   = FAST;
          steps_d   = '0;
          timer_clr = 1'b1;
        end else begin
          steps_d = steps_q + 1'b1;
        end
      end
    end

    moving_d = (pady_d != pady_q);
    // Draw compare widened by one bit so pady + PADDLE_HEIGHT cannot wrap.
    draw_d = (icolcount == COL_X) &&
             ({1'b0, irowcount} >= {1'b0, pady_q}) &&
             ({1'b0, irowcount} < ({1'b0, pady_q} + PH_EXT));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dir_q    <= NONE;
      steps_q  <= '0;
      pady_q   <= CENTER_Y;
      moving_q <= 1'b0;
      draw_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      steps_q  <= steps_d;
      pady_q   <= pady_d;
      moving_q <= moving_d;
      draw_q   <= draw_d;
    end
  end

  assign opaddley    = pady_q;
  assign omoving     = moving_q;
  assign odrawpaddle = draw_q;

endmodule
